// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared widths, grant encoding and write-entry type for the VRAM arbiter
package vram_pkg;

  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_SCAN,
    GNT_DRAIN
  } grant_t;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - synchronous GPU write FIFO, power-of-two depth
// Pointers carry one extra MSB so full and empty are distinguishable without a counter.
module vram_wr_fifo #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [ADDR_W-1:0]         head_addr,
  output logic [DATA_W-1:0]         head_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr[PTR_W-1:0]] <= push_addr;
      data_mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr[PTR_W-1:0]];
  assign head_data = data_mem[rd_ptr[PTR_W-1:0]];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign level     = wr_ptr - rd_ptr;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM port arbiter: scanout reads first, buffered GPU writes drain when free
// Optional write-stall counter built only when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic                          SCAN_REQ,
  input  logic [ADDR_W-1:0]             SCAN_ADDR,
  output logic [DATA_W-1:0]             SCAN_Q,
  output logic                          SCAN_QV,
  input  logic                          WR_VALID,
  output logic                          WR_READY,
  input  logic [ADDR_W-1:0]             WR_ADDR,
  input  logic [DATA_W-1:0]             WR_DATA,
  output logic [ADDR_W-1:0]             VRAM_ADDR,
  output logic                          VRAM_WE,
  output logic [DATA_W-1:0]             VRAM_D,
  input  logic [DATA_W-1:0]             VRAM_Q,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic [15:0]                   STALL_CNT
);

  grant_t            grant;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        qv_pipe;

  assign WR_READY = !fifo_full && RESETN;
  assign push     = WR_VALID && WR_READY;
  assign pop      = (grant == GNT_DRAIN);

  vram_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .resetn    (RESETN),
    .push      (push),
    .push_addr (WR_ADDR),
    .push_data (WR_DATA),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (FIFO_LEVEL)
  );

  // A write pushed this cycle is not visible in fifo_empty yet, so it never bypasses.
  always_comb begin
    grant = GNT_IDLE;
    if (SCAN_REQ)
      grant = GNT_SCAN;
    else if (!fifo_empty)
      grant = GNT_DRAIN;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      VRAM_ADDR <= '0;
      VRAM_WE   <= 1'b0;
      VRAM_D    <= '0;
      qv_pipe   <= 2'b00;
    end else begin
      if (grant == GNT_DRAIN) begin
        VRAM_ADDR <= head_addr;
        VRAM_D    <= head_data;
        VRAM_WE   <= 1'b1;
      end else begin
        VRAM_ADDR <= SCAN_ADDR;
        VRAM_WE   <= 1'b0;
      end
      qv_pipe <= {qv_pipe[0], (grant == GNT_SCAN)};
    end
  end

  assign SCAN_Q  = VRAM_Q;
  assign SCAN_QV = qv_pipe[1];

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RESETN)
      STALL_CNT <= '0;
    else if (WR_VALID && !WR_READY && (STALL_CNT != 16'hFFFF))
      STALL_CNT <= STALL_CNT + 16'd1;
  end
`else
  assign STALL_CNT = '0;
`endif

endmodule
